iob_bus_split2: RTL

- Downstream stage of the CPU wrapper's IOb native request/response buses, one instance per bus (instruction, data).
- Routes each master request to one of two slaves (s0: boot/internal memory, s1: external memory) by a single address bit, and returns responses to the master in order.
- Tracks outstanding reads so response data is never taken from the wrong slave.
- Blocks a target switch while reads to the other target are still pending.

---
 rtl/iob_bus_split2.sv | 96 +++++++++
 1 files changed

// File: rtl/iob_bus_split2.sv
// Two-way IOb request splitter: routes each master request to s0 or s1 by one
// address bit and returns read data in order from whichever slave owns the pending reads.
module iob_bus_split2 #(
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    parameter  int SPLIT_BIT = ADDR_W - 1,
    parameter  int MAX_PEND  = 4,
    localparam int STRB_W    = DATA_W / 8,
    localparam int REQ_W     = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W    = DATA_W + 2
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic [REQ_W-1:0]  m_req_i,
    output logic [RESP_W-1:0] m_resp_o,
    output logic [REQ_W-1:0]  s0_req_o,
    input  logic [RESP_W-1:0] s0_resp_i,
    output logic [REQ_W-1:0]  s1_req_o,
    input  logic [RESP_W-1:0] s1_resp_i,
    output logic              err_o
);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);

    logic              m_avalid;
    logic [ADDR_W-1:0] m_addr;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              sel;
    logic              s0_ready, s0_rvalid, s1_ready, s1_rvalid;
    logic [DATA_W-1:0] s0_rdata, s1_rdata;

    logic [PW-1:0]     pend_cnt, pend_nxt, pend_eff;
    logic              owner;
    logic              own_rvalid, oth_rvalid, good_rv, err_evt;
    logic [DATA_W-1:0] own_rdata;
    logic              stall, m_ready, rd_acc;

    assign m_avalid = m_req_i[REQ_W-1];
    assign m_addr   = m_req_i[REQ_W-2 -: ADDR_W];
    assign m_wdata  = m_req_i[STRB_W +: DATA_W];
    assign m_wstrb  = m_req_i[STRB_W-1:0];
    assign sel      = m_addr[SPLIT_BIT];
    assign s_addr   = m_addr & ~(ADDR_W'(1) << SPLIT_BIT);

    assign s0_ready  = s0_resp_i[0];
    assign s0_rvalid = s0_resp_i[1];
    assign s0_rdata  = s0_resp_i[RESP_W-1:2];
    assign s1_ready  = s1_resp_i[0];
    assign s1_rvalid = s1_resp_i[1];
    assign s1_rdata  = s1_resp_i[RESP_W-1:2];

    always_comb begin
        own_rvalid = owner ? s1_rvalid : s0_rvalid;
        oth_rvalid = owner ? s0_rvalid : s1_rvalid;
        own_rdata  = owner ? s1_rdata  : s0_rdata;
        good_rv    = own_rvalid && (pend_cnt != '0);
        err_evt    = oth_rvalid || ((s0_rvalid || s1_rvalid) && (pend_cnt == '0));
        // A response retiring this cycle frees its slot now, so a switch or a
        // full queue can accept in the very cycle the blocking read completes.
        pend_eff   = pend_cnt - {{(PW-1){1'b0}}, good_rv};
        stall      = ((pend_eff != '0) && (sel != owner)) || (pend_eff == PEND_MAX);
        m_ready    = (sel ? s1_ready : s0_ready) && !stall;
        rd_acc     = m_avalid && m_ready && (m_wstrb == '0);
    end

    always_comb begin
        pend_nxt = pend_cnt;
        if (rd_acc && !good_rv)
            pend_nxt = pend_cnt + 1'b1;
        else if (good_rv && !rd_acc)
            pend_nxt = pend_cnt - 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pend_cnt <= '0;
            owner    <= 1'b0;
            err_o    <= 1'b0;
        end else if (cke_i) begin
            pend_cnt <= pend_nxt;
            if (rd_acc)
                owner <= sel;
            if (err_evt)
                err_o <= 1'b1;
        end
    end

    always_comb begin
        s0_req_o = {m_avalid && !stall && !sel, s_addr, m_wdata, m_wstrb};
        s1_req_o = {m_avalid && !stall &&  sel, s_addr, m_wdata, m_wstrb};
        m_resp_o = {good_rv ? own_rdata : {DATA_W{1'b0}}, good_rv, m_ready};
    end
endmodule
